// File: rtl/byte_strip_multi_if.sv
// Symbol-mux to lane-serializer bus for byte_strip_multi.
// lane_rev exists only when BYTE_STRIP_LANE_REVERSAL_EN is defined.
interface byte_strip_multi_if #(
  parameter int BITS      = 8,
  parameter int NUM_LANES = 4
);
  logic [BITS-1:0]           d_in;
  logic                      valid_in;
  logic [2:0]                width_sel;
`ifdef BYTE_STRIP_LANE_REVERSAL_EN
  logic                      lane_rev;
`endif
  logic [NUM_LANES*BITS-1:0] lane_data;
  logic [NUM_LANES-1:0]      lane_valid;
  logic                      width_err;

`ifdef BYTE_STRIP_LANE_REVERSAL_EN
  modport master (output d_in, valid_in, width_sel, lane_rev,
                  input  lane_data, lane_valid, width_err);
  modport slave  (input  d_in, valid_in, width_sel, lane_rev,
                  output lane_data, lane_valid, width_err);
`else
  modport master (output d_in, valid_in, width_sel,
                  input  lane_data, lane_valid, width_err);
  modport slave  (input  d_in, valid_in, width_sel,
                  output lane_data, lane_valid, width_err);
`endif
endinterface

// File: rtl/byte_strip_multi.sv
// Parametrised byte striper: gathers 1<<width_sel bytes, releases them as one aligned set,
// PAD-fills partial sets. Optional lane reversal via BYTE_STRIP_LANE_REVERSAL_EN.

// Per-lane release selector: picks staged byte, the closing byte, PAD, or 0.
module byte_strip_multi_lane #(
  parameter int          BITS      = 8,
  parameter int          NUM_LANES = 4,
  parameter int          LANE      = 0,
  parameter logic [BITS-1:0] PAD   = 8'hF7
) (
  input  logic [NUM_LANES-1:0][BITS-1:0] stage,
  input  logic [BITS-1:0]                d_in,
  input  logic [3:0]                     act,
  input  logic [2:0]                     ptr,
  input  logic                           last,
  input  logic                           rev,
  output logic [BITS-1:0]                d,
  output logic                           v
);
  localparam logic [3:0] LI = 4'(LANE);
  logic [3:0]      j;
  logic [BITS-1:0] sel;

  always_comb begin
    v   = (LI < act);
    j   = rev ? (act - 4'd1 - LI) : LI;
    sel = '0;
    for (int i = 0; i < NUM_LANES; i++)
      if (4'(i) == j) sel = stage[i];
    d = '0;
    if (v) begin
      if (j < {1'b0, ptr})                d = sel;
      else if (last && j == {1'b0, ptr})  d = d_in;
      else                                d = PAD;
    end
  end
endmodule

module byte_strip_multi #(
  parameter int              BITS       = 8,
  parameter int              NUM_LANES  = 4,
  parameter logic [BITS-1:0] PAD_SYMBOL = 8'hF7
) (
  input logic               clk,
  input logic               reset_L,
  byte_strip_multi_if.slave bus
);
  localparam int LW = $clog2(NUM_LANES);

  typedef enum logic {IDLE, FILL} state_t;
  state_t state;

  logic [NUM_LANES-1:0][BITS-1:0] stage, lane_q, rel_data;
  logic [NUM_LANES-1:0]           lane_vq, rel_valid;
  logic [2:0]                     ptr, act_w, cur_w;
  logic [3:0]                     act;
  logic                           err_seen, legal, last, rel, flush, fire, cur_rev;

`ifdef BYTE_STRIP_LANE_REVERSAL_EN
  logic rev_q;
  assign cur_rev = (state == IDLE) ? bus.lane_rev : rev_q;
`else
  assign cur_rev = 1'b0;
`endif

  // At set start the live width_sel governs; mid-set the latched one does.
  assign cur_w = (state == IDLE) ? bus.width_sel : act_w;
  assign act   = 4'd1 << cur_w;
  assign legal = (cur_w <= 3'(LW));
  assign last  = bus.valid_in && ({1'b0, ptr} == act - 4'd1);
  assign rel   = last && (state == FILL || legal);
  assign flush = (state == FILL) && !bus.valid_in;
  assign fire  = rel || flush;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    byte_strip_multi_lane #(
      .BITS(BITS), .NUM_LANES(NUM_LANES), .LANE(k), .PAD(PAD_SYMBOL)
    ) u_lane (
      .stage(stage), .d_in(bus.d_in), .act(act), .ptr(ptr), .last(last),
      .rev(cur_rev), .d(rel_data[k]), .v(rel_valid[k])
    );
  end

  assign bus.lane_data  = lane_q;
  assign bus.lane_valid = lane_vq;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state         <= IDLE;
      ptr           <= '0;
      act_w         <= '0;
      stage         <= '0;
      lane_q        <= '0;
      lane_vq       <= '0;
      err_seen      <= 1'b0;
      bus.width_err <= 1'b0;
`ifdef BYTE_STRIP_LANE_REVERSAL_EN
      rev_q         <= 1'b0;
`endif
    end else begin
      bus.width_err <= 1'b0;
      lane_vq       <= '0;
      if (fire) begin
        lane_q  <= rel_data;
        lane_vq <= rel_valid;
      end
      case (state)
        IDLE: if (bus.valid_in) begin
          if (legal) begin
            act_w    <= bus.width_sel;
            err_seen <= 1'b0;
`ifdef BYTE_STRIP_LANE_REVERSAL_EN
            rev_q    <= bus.lane_rev;
`endif
            if (act != 4'd1) begin
              stage[0] <= bus.d_in;
              ptr      <= 3'd1;
              state    <= FILL;
            end
          end else begin
            bus.width_err <= 1'b1;
          end
        end
        FILL: begin
          if (bus.width_sel != act_w && !err_seen) begin
            bus.width_err <= 1'b1;
            err_seen      <= 1'b1;
          end
          if (bus.valid_in) begin
            for (int i = 0; i < NUM_LANES; i++)
              if (3'(i) == ptr) stage[i] <= bus.d_in;
            if (last) begin
              ptr   <= '0;
              state <= IDLE;
            end else begin
              ptr <= ptr + 3'd1;
            end
          end else begin
            ptr   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_byte_strip_multi.sv
// Directed bench for byte_strip_multi (NUM_LANES=4), hand-computed expected lane sets.
module tb_byte_strip_multi;
  logic clk = 1'b0;
  logic reset_L;
  int   n_cmp = 0;
  int   n_err = 0;

  byte_strip_multi_if #(.BITS(8), .NUM_LANES(4)) bus ();

  byte_strip_multi #(.BITS(8), .NUM_LANES(4), .PAD_SYMBOL(8'hF7)) dut (
    .clk(clk), .reset_L(reset_L), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic [2:0] w);
    @(negedge clk);
    bus.valid_in  = v;
    bus.d_in      = d;
    bus.width_sel = w;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] data, input logic [3:0] vld,
                         input logic err);
    chk({tag, ".data"}, 64'(bus.lane_data), 64'(data));
    chk({tag, ".valid"}, 64'(bus.lane_valid), 64'(vld));
    chk({tag, ".err"}, 64'(bus.width_err), 64'(err));
  endtask

  initial begin
    reset_L       = 1'b0;
    bus.valid_in  = 1'b0;
    bus.d_in      = '0;
    bus.width_sel = '0;
`ifdef BYTE_STRIP_LANE_REVERSAL_EN
    bus.lane_rev  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    reset_L = 1'b1;

    // x4 back-to-back sets
    step(1, 8'h01, 3'd2); chk("x4.b1.valid", 64'(bus.lane_valid), 64'h0);
    step(1, 8'h02, 3'd2);
    step(1, 8'h03, 3'd2); chk("x4.b3.valid", 64'(bus.lane_valid), 64'h0);
    step(1, 8'h04, 3'd2); chk_out("x4.set1", 32'h04030201, 4'hF, 1'b0);
    step(1, 8'h05, 3'd2); chk_out("x4.hold", 32'h04030201, 4'h0, 1'b0);
    step(1, 8'h06, 3'd2);
    step(1, 8'h07, 3'd2); chk("x4.b7.valid", 64'(bus.lane_valid), 64'h0);
    step(1, 8'h08, 3'd2); chk_out("x4.set2", 32'h08070605, 4'hF, 1'b0);
    step(0, 8'h00, 3'd2); chk("x4.idle.valid", 64'(bus.lane_valid), 64'h0);

    // x2 full set, then partial set flushed with PAD
    step(1, 8'hAA, 3'd1); chk("x2.aa.valid", 64'(bus.lane_valid), 64'h0);
    step(1, 8'hBB, 3'd1); chk_out("x2.set", 32'h0000BBAA, 4'h3, 1'b0);
    step(1, 8'hCC, 3'd1); chk("x2.cc.valid", 64'(bus.lane_valid), 64'h0);
    step(0, 8'h00, 3'd1); chk_out("x2.flush", 32'h0000F7CC, 4'h3, 1'b0);

    // illegal x8 on a 4-lane build: byte dropped, pointer untouched
    step(1, 8'h55, 3'd3); chk_out("ill.pulse", 32'h0000F7CC, 4'h0, 1'b1);
    step(0, 8'h00, 3'd2); chk("ill.clear", 64'(bus.width_err), 64'h0);
    step(1, 8'h01, 3'd2);
    step(1, 8'h02, 3'd2);
    step(1, 8'h03, 3'd2); chk("ill.b3.valid", 64'(bus.lane_valid), 64'h0);
    step(1, 8'h04, 3'd2); chk_out("ill.after", 32'h04030201, 4'hF, 1'b0);

    // width change mid-set: one error pulse, set completes at latched x4
    step(1, 8'h11, 3'd2);
    step(1, 8'h22, 3'd2); chk("wc.22.err", 64'(bus.width_err), 64'h0);
    step(1, 8'h33, 3'd0); chk_out("wc.33", 32'h04030201, 4'h0, 1'b1);
    step(1, 8'h44, 3'd0); chk_out("wc.set", 32'h44332211, 4'hF, 1'b0);
    step(1, 8'h55, 3'd0); chk_out("wc.x1", 32'h00000055, 4'h1, 1'b0);
    step(0, 8'h00, 3'd0); chk_out("wc.idle", 32'h00000055, 4'h0, 1'b0);

    // reset mid-set discards the partial set
    step(1, 8'h10, 3'd2);
    step(1, 8'h20, 3'd2);
    #2;
    reset_L = 1'b0;
    #1;
    chk_out("rst.async", 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    bus.valid_in = 1'b0;
    @(negedge clk);
    reset_L = 1'b1;
    step(1, 8'hA1, 3'd2);
    step(1, 8'hA2, 3'd2); chk("rst.a2.valid", 64'(bus.lane_valid), 64'h0);
    step(1, 8'hA3, 3'd2); chk("rst.a3.valid", 64'(bus.lane_valid), 64'h0);
    step(1, 8'hA4, 3'd2); chk_out("rst.set", 32'hA4A3A2A1, 4'hF, 1'b0);

    // flush immediately followed by a new set
    step(1, 8'h01, 3'd2);
    step(1, 8'h02, 3'd2);
    step(0, 8'h00, 3'd2); chk_out("fl.flush", 32'hF7F70201, 4'hF, 1'b0);
    step(1, 8'h03, 3'd2); chk("fl.b3.valid", 64'(bus.lane_valid), 64'h0);
    step(1, 8'h04, 3'd2);
    step(1, 8'h05, 3'd2);
    step(1, 8'h06, 3'd2); chk_out("fl.next", 32'h06050403, 4'hF, 1'b0);

`ifdef BYTE_STRIP_LANE_REVERSAL_EN
    bus.lane_rev = 1'b1;
    step(1, 8'h01, 3'd2);
    step(1, 8'h02, 3'd2);
    step(1, 8'h03, 3'd2);
    step(0, 8'h00, 3'd2); chk_out("rev.flush", 32'h010203F7, 4'hF, 1'b0);
    bus.lane_rev = 1'b0;
`endif

    step(0, 8'h00, 3'd2); chk("end.valid", 64'(bus.lane_valid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/byte_strip_multi.md
Name: byte_strip_multi

Overview:
- Parametrised successor to the fixed 4-lane byte striper in the PHY transmit path.
- Sits between the symbol mux (byte stream + valid) and the per-lane serializers.
- Supports a configurable lane count and a runtime link width (x1/x2/x4/x8).
- Aligns each striped set, pads partial sets with a PAD symbol, and flags width/configuration errors.

Parameters:
- BITS, 8, symbol width in bits.
- NUM_LANES, 4, physical lane count; power of two, 1..8.
- PAD_SYMBOL, 8'hF7, symbol used to fill unused lanes of a partial set (K23.7 PAD).

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- d_in  input  BITS  input symbol.
- valid_in  input  1  d_in valid this cycle (the DK flag from the mux).
- width_sel  input  3  link width code: active lanes = 1<<width_sel.
- lane_data  output  NUM_LANES*BITS  flat lane bus; lane k occupies bits [k*BITS +: BITS].
- lane_valid  output  NUM_LANES  per-lane valid for the released set.
- width_err  output  1  one-cycle error pulse.

Behaviour:
- Reset (async assert, sync-safe deassert): ptr=0, staging=0, act_w=0, lane_data=0, lane_valid=0, width_err=0, state=IDLE.
- Active width ACT = 1<<width_sel is legal only if ACT <= NUM_LANES.
- IDLE (ptr=0), valid_in=1, legal width_sel:
  - Latch act_w=width_sel.
  - Store d_in in stage[0], ptr=1, go to FILL.
  - If ACT==1, release immediately instead (see release) and stay in IDLE.
- IDLE, valid_in=1, illegal width_sel:
  - Drop the byte; width_err=1 for one cycle; stay IDLE.
- FILL, valid_in=1:
  - stage[ptr]=d_in, ptr+1.
  - If ptr==ACT-1, release and return to IDLE with ptr=0.
- Release:
  - Registered; lane_data and lane_valid update at the edge that captures the last byte (1-cycle latency from that byte).
  - lane_valid = low ACT bits set.
  - Lanes >= ACT carry 0 with valid 0.
  - lane_valid is high for exactly one cycle per set.
- FILL, valid_in=0 (partial set):
  - Flush: lanes ptr..ACT-1 are filled with PAD_SYMBOL and released, with all ACT lanes valid.
  - ptr=0, go to IDLE.
- Width change mid-set:
  - If width_sel != act_w while in FILL, width_err pulses for one cycle (once per set, on the first mismatching cycle).
  - The set completes using the latched act_w; the new width takes effect at the next set start.
- No release cycle: lane_valid=0 and lane_data holds its previous value.
- Back-to-back sets: a release edge and the capture of the next set's first byte occur in the same cycle without loss.
- Flush followed immediately by valid_in=1: the flush release and the new set's stage[0] capture happen on consecutive edges with no byte dropped.
- Bytes are never dropped except on an illegal width at set start.
- Reset mid-set: the partial set is discarded with no flush output.

Optional Feature:
- BYTE_STRIP_LANE_REVERSAL_EN defined:
  - Adds input port lane_rev (1 bit, sampled and latched at set start alongside act_w).
  - When latched 1, byte k of a set is driven on lane ACT-1-k.
  - PAD fill then occupies the lowest lanes.
  - lane_valid is unchanged.
- Not defined:
  - Port absent; byte k always goes to lane k.

Test Plan:
- NUM_LANES=4, width_sel=2, valid_in=1 for 8 cycles with d_in=01..08 -> lane_data=04_03_02_01 valid=1111 one cycle after byte 04, then 08_07_06_05 valid=1111 four cycles later; no gaps.
- width_sel=1, bytes AA,BB,CC -> {BB,AA} valid=0011 after BB; CC then valid_in=0 -> {F7,CC} valid=0011; lanes 2-3 remain 0.
- width_sel=3 with NUM_LANES=4, valid_in=1 d_in=55 -> width_err pulses 1 cycle, no lane_valid, ptr stays 0; then width_sel=2 proceeds normally.
- width_sel=2, send 11,22, switch width_sel=0, send 33,44 -> width_err pulses once; release {44,33,22,11} valid=1111; next byte 55 released alone on lane 0 valid=0001.
- width_sel=2, send 10,20, assert reset_L=0 mid-cycle -> all outputs 0 immediately; after release, 4 new bytes produce a clean aligned set with no remnant of 10/20.
- BYTE_STRIP_LANE_REVERSAL_EN defined, lane_rev=1, width_sel=2, bytes 01,02,03 then valid_in=0 -> lane3..0 = 01,02,03,F7, valid=1111.
